// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcodes and buffer state type shared by the ALU, the arbiter and drivers
//
// Purpose : common opcode encoding for the shared ALU and the response-buffer state type.
// Ports   : none (package).

package alu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_OR  = 2'b10;
    localparam logic [1:0] OP_AND = 2'b11;

    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } bufState_t;

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational add/sub/or/and datapath
//
// Purpose : single shared ALU; add and sub wrap modulo 2^WIDTH, no carry out.
// Ports   : a, b  in  WIDTH  operands
//           op    in  2      opcode (OP_ADD/OP_SUB/OP_OR/OP_AND)
//           y     out WIDTH  result

module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = '0;
        case (op)
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_OR:   y = a | b;
            OP_AND:  y = a & b;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin sharing of one ALU with a one-entry tagged response buffer
//
// Purpose : NREQ requesters compete for one combinational ALU. A round-robin
//           grant picks one valid requester per cycle whenever the response
//           buffer can take a result; the result is registered with the
//           requester index.
// Ports   : clk        in   1           rising-edge clock
//           rst_n      in   1           asynchronous active-low reset
//           req_valid  in   NREQ        requester i has an operation pending
//           req_ready  out  NREQ        one-hot grant, transfer on valid&ready
//           req_a      in   NREQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH]
//           req_b      in   NREQ*WIDTH  operand B, same packing
//           req_op     in   2*NREQ      opcode, requester i at [2*i +: 2]
//           rsp_valid  out  1           response buffer holds a result
//           rsp_ready  in   1           consumer takes the response this cycle
//           rsp_data   out  WIDTH       ALU result
//           rsp_id     out  IDW         index of the issuing requester

module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [2*NREQ-1:0]     req_op,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WIDTH-1:0]      rsp_data,
    output logic [IDW-1:0]        rsp_id
);

    localparam logic [IDW:0]   NREQ_EXT = (IDW + 1)'(NREQ);
    localparam logic [IDW-1:0] LAST_IDX = IDW'(NREQ - 1);

    bufState_t        state;
    bufState_t        stateNext;
    logic [IDW-1:0]   rrPtr;
    logic [IDW-1:0]   grantIdx;
    logic             grantFound;
    logic             canAccept;
    logic             grant;
    logic [2*NREQ-1:0] validDouble;
    logic [NREQ-1:0]  validRot;
    logic [IDW:0]     idxSum;
    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] opB;
    logic [1:0]       opSel;
    logic [WIDTH-1:0] aluY;
    logic [WIDTH-1:0] rspDataQ;
    logic [IDW-1:0]   rspIdQ;

    // Rotate the valid vector so bit 0 is the requester at rrPtr; the first
    // set bit k then maps back to requester (rrPtr + k) mod NREQ.
    always_comb begin
        validDouble = {req_valid, req_valid};
        validRot    = NREQ'(validDouble >> rrPtr);
        grantFound  = 1'b0;
        grantIdx    = '0;
        idxSum      = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!grantFound && validRot[k]) begin
                grantFound = 1'b1;
                idxSum     = {1'b0, rrPtr} + (IDW + 1)'(k);
                if (idxSum >= NREQ_EXT) begin
                    idxSum = idxSum - NREQ_EXT;
                end
                grantIdx = idxSum[IDW-1:0];
            end
        end
    end

    // rst_n gates the grant so req_ready stays low for the whole reset pulse,
    // not just after the first clock.
    assign canAccept = (state == BUF_EMPTY) || rsp_ready;
    assign grant     = canAccept && grantFound && rst_n;

    always_comb begin
        req_ready = '0;
        if (grant) begin
            req_ready[grantIdx] = 1'b1;
        end
    end

    always_comb begin
        opA   = '0;
        opB   = '0;
        opSel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grantIdx == IDW'(i)) begin
                opA   = req_a[i*WIDTH +: WIDTH];
                opB   = req_b[i*WIDTH +: WIDTH];
                opSel = req_op[2*i +: 2];
            end
        end
    end

    alu_core #(
        .WIDTH (WIDTH)
    ) u_alu (
        .a  (opA),
        .b  (opB),
        .op (opSel),
        .y  (aluY)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BUF_EMPTY;
        end else begin
            state <= stateNext;
        end
    end

    // FULL with rsp_ready and a new grant stays FULL: drain and refill together.
    always_comb begin
        stateNext = state;
        case (state)
            BUF_EMPTY: begin
                if (grant) begin
                    stateNext = BUF_FULL;
                end
            end
            BUF_FULL: begin
                if (rsp_ready && !grant) begin
                    stateNext = BUF_EMPTY;
                end
            end
            default: stateNext = BUF_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rspDataQ <= '0;
            rspIdQ   <= '0;
        end else if (grant) begin
            rspDataQ <= aluY;
            rspIdQ   <= grantIdx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rrPtr <= '0;
        end else if (grant) begin
            rrPtr <= (grantIdx == LAST_IDX) ? '0 : grantIdx + 1'b1;
        end
    end

    assign rsp_valid = (state == BUF_FULL);
    assign rsp_data  = rspDataQ;
    assign rsp_id    = rspIdQ;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - scoreboard bench for the shared-ALU round-robin arbiter

module tb_alu_share_arbiter;
    import alu_pkg::*;

    localparam int NREQ = 4;
    localparam int W    = 4;

    typedef struct {
        logic [3:0] data;
        logic [1:0] id;
    } rsp_t;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic [7:0]  req_op;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [3:0]  rsp_data;
    logic [1:0]  rsp_id;

    int   vectors = 0;
    int   miscompares = 0;
    int   mdlPtr = 0;
    int   lastGrant = -1;
    logic [3:0] oneShot = '0;
    rsp_t sbQ[$];

    alu_share_arbiter #(
        .NREQ  (NREQ),
        .WIDTH (W),
        .IDW   (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    function automatic logic [3:0] aluRef(logic [3:0] a, logic [3:0] b, logic [1:0] op);
        case (op)
            2'd0:    return 4'((5'(a) + 5'(b)) % 16);
            2'd1:    return 4'((5'(a) + 5'd16 - 5'(b)) % 16);
            2'd2:    return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic int modelPick(logic [3:0] v, int p);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic setReq(int i, logic [3:0] a, logic [3:0] b, logic [1:0] op, logic once);
        req_a[i*4 +: 4] = a;
        req_b[i*4 +: 4] = b;
        req_op[i*2 +: 2] = op;
        req_valid[i] = 1'b1;
        oneShot[i] = once;
    endtask

    // One clock: check outputs against the model at the falling edge, advance
    // the model, then move past the rising edge.
    task automatic step();
        int         g;
        logic [3:0] expRdy;
        logic       full;
        rsp_t       r;
        @(negedge clk);
        full = (sbQ.size() != 0);
        chk("rsp_valid", 32'(rsp_valid), 32'(full));
        if (full) begin
            chk("rsp_data", 32'(rsp_data), 32'(sbQ[0].data));
            chk("rsp_id", 32'(rsp_id), 32'(sbQ[0].id));
        end
        g = -1;
        if (rst_n && (!full || rsp_ready)) g = modelPick(req_valid, mdlPtr);
        expRdy = '0;
        if (g >= 0) expRdy[g] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(expRdy));
        if (full && rsp_ready) void'(sbQ.pop_front());
        if (g >= 0) begin
            r.data = aluRef(req_a[g*4 +: 4], req_b[g*4 +: 4], req_op[g*2 +: 2]);
            r.id   = 2'(g);
            sbQ.push_back(r);
            mdlPtr = (g + 1) % NREQ;
        end
        lastGrant = g;
        @(posedge clk);
        #1;
        if (g >= 0 && oneShot[g]) req_valid[g] = 1'b0;
    endtask

    task automatic resetPulse();
        rst_n = 1'b0;
        #1;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        sbQ.delete();
        mdlPtr = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int rrExp[6] = '{0, 1, 2, 3, 0, 1};
        int zeroGrants;
        int got3;

        rst_n = 1'b0;
        req_valid = 4'hF;
        req_a = '0;
        req_b = '0;
        req_op = '0;
        rsp_ready = 1'b1;

        // Reset with every requester asking: no grant may leak out.
        resetPulse();
        req_valid = '0;

        // Single requests.
        setReq(0, 4'h9, 4'h8, OP_ADD, 1'b1);
        step();
        chk("req0_add_data", 32'(rsp_data), 32'h1);
        chk("req0_add_id", 32'(rsp_id), 32'd0);
        setReq(1, 4'h3, 4'h5, OP_SUB, 1'b1);
        step();
        chk("req1_sub_data", 32'(rsp_data), 32'hE);
        chk("req1_sub_id", 32'(rsp_id), 32'd1);
        step();

        // Round robin from a fresh pointer with all four valid.
        resetPulse();
        for (int i = 0; i < NREQ; i++) setReq(i, 4'(i + 1), 4'(2 * i), 2'(i), 1'b0);
        for (int n = 0; n < 6; n++) begin
            step();
            chk("rr_grant", 32'(lastGrant), 32'(rrExp[n]));
            chk("rr_id", 32'(rsp_id), 32'(rrExp[n]));
        end
        req_valid = '0;
        step();

        // Backpressure: pointer sits at 2.
        setReq(2, 4'hA, 4'h5, OP_OR, 1'b1);
        step();
        rsp_ready = 1'b0;
        setReq(3, 4'hC, 4'h6, OP_AND, 1'b1);
        for (int n = 0; n < 3; n++) begin
            step();
            chk("bp_hold_data", 32'(rsp_data), 32'hF);
            chk("bp_hold_id", 32'(rsp_id), 32'd2);
            chk("bp_no_grant", 32'(lastGrant), 32'hFFFF_FFFF);
        end
        rsp_ready = 1'b1;
        step();
        chk("bp_refill_grant", 32'(lastGrant), 32'd3);
        chk("bp_refill_data", 32'(rsp_data), 32'h4);
        chk("bp_refill_id", 32'(rsp_id), 32'd3);
        step();

        // Fairness: req0 hogs, req3 shows up once.
        setReq(0, 4'h7, 4'h7, OP_ADD, 1'b0);
        step();
        step();
        setReq(3, 4'hF, 4'h1, OP_ADD, 1'b1);
        zeroGrants = 0;
        got3 = 0;
        for (int n = 0; n < 4 && got3 == 0; n++) begin
            step();
            if (lastGrant == 3) got3 = 1;
            else if (lastGrant == 0) zeroGrants++;
        end
        chk("fair_req3_granted", 32'(got3), 32'd1);
        chk("fair_wait_grants", 32'(zeroGrants), 32'd0);
        req_valid = '0;
        step();

        // Async reset with a response held.
        rsp_ready = 1'b0;
        setReq(1, 4'h2, 4'h2, OP_ADD, 1'b1);
        step();
        chk("pre_rst_valid", 32'(rsp_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(rsp_valid), 32'd0);
        chk("async_rst_data", 32'(rsp_data), 32'd0);
        chk("async_rst_ready", 32'(req_ready), 32'd0);
        sbQ.delete();
        mdlPtr = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        setReq(3, 4'h1, 4'h1, OP_ADD, 1'b1);
        setReq(0, 4'h1, 4'h2, OP_ADD, 1'b1);
        step();
        chk("post_rst_ptr_grant", 32'(lastGrant), 32'd0);
        step();
        chk("post_rst_next_grant", 32'(lastGrant), 32'd3);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
